// File: rtl/md5_read_scheduler.sv
// Round-robin AXI4 AR/R sharing between NUM_LANES MD5 lanes, routing R beats by rid.
// Optional per-lane completed-burst counters when MD5_SCHED_STATS_EN is defined.

module md5_sched_lane #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_dec,
  output logic        o_full,
  output logic        o_unf,
  output logic [31:0] o_stat
);
  logic [7:0] r_cnt;

  assign o_full = (r_cnt >= 8'(MAX_OUTSTANDING));
  assign o_unf  = i_dec && (r_cnt == 8'd0);

  // Simultaneous issue and completion on one lane cancel out.
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_inc && !i_dec) begin
      if (!o_full) r_cnt <= r_cnt + 8'd1;
    end else if (i_dec && !i_inc && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
  end

`ifdef MD5_SCHED_STATS_EN
  logic [31:0] r_stat;
  always_ff @(posedge clk) begin
    if (rst) r_stat <= '0;
    else if (i_dec) r_stat <= r_stat + 32'd1;
  end
  assign o_stat = r_stat;
`else
  assign o_stat = '0;
`endif
endmodule

module md5_read_scheduler #(
  parameter int NUM_LANES       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_W            = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_LANES-1:0]    lane_req_valid,
  input  logic [NUM_LANES*64-1:0] lane_req_addr,
  input  logic [NUM_LANES*8-1:0]  lane_req_len,
  output logic [NUM_LANES-1:0]    lane_req_ready,
  output logic [NUM_LANES-1:0]    lane_resp_valid,
  output logic [511:0]            lane_resp_data,
  output logic                    lane_resp_last,
  input  logic [NUM_LANES-1:0]    lane_resp_ready,
  output logic [ID_W-1:0]         arid,
  output logic [63:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [511:0]            rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    err_sticky,
  output logic [NUM_LANES*32-1:0] stat_bursts
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  state_t r_state, w_state_nxt;

  logic [LW-1:0]        r_rr_ptr, r_win, w_win;
  logic                 w_found, w_ar_hs, w_r_hs, w_rid_ok, r_err;
  logic [ID_W-1:0]      r_arid;
  logic [63:0]          r_araddr;
  logic [7:0]           r_arlen;
  logic [NUM_LANES-1:0] w_full, w_elig, w_ar_inc, w_r_done, w_unf;

  assign w_elig = lane_req_valid & ~w_full;

  // First eligible lane at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      if (!w_found && w_elig[j]) begin
        w_found = 1'b1;
        w_win   = LW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    lane_req_ready = '0;
    case (r_state)
      S_IDLE: if (w_found) begin
        lane_req_ready[w_win] = 1'b1;
        w_state_nxt           = S_ISSUE;
      end
      S_ISSUE: if (arready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ar_hs = (r_state == S_ISSUE) && arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_win    <= '0;
      r_arid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_win    <= w_win;
        r_arid   <= ID_W'(w_win);
        r_araddr <= lane_req_addr[int'(w_win)*64 +: 64];
        r_arlen  <= lane_req_len[int'(w_win)*8 +: 8];
      end
      if (w_ar_hs) r_rr_ptr <= (r_win == LW'(NUM_LANES - 1)) ? '0 : r_win + LW'(1);
    end
  end

  assign arvalid = (r_state == S_ISSUE);
  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = 3'b110;

  // Beats with an unknown rid are swallowed so the interconnect never stalls.
  assign w_rid_ok       = (rid < ID_W'(NUM_LANES));
  assign rready         = w_rid_ok ? lane_resp_ready[rid[LW-1:0]] : 1'b1;
  assign w_r_hs         = rvalid && rready;
  assign lane_resp_data = rdata;
  assign lane_resp_last = rlast;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_resp_valid[i] = rvalid && (rid == ID_W'(i));
      w_r_done[i]        = w_r_hs && rlast && (rid == ID_W'(i));
      w_ar_inc[i]        = w_ar_hs && (r_win == LW'(i));
    end
  end

  md5_sched_lane #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_lane [NUM_LANES-1:0] (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_ar_inc),
    .i_dec  (w_r_done),
    .o_full (w_full),
    .o_unf  (w_unf),
    .o_stat (stat_bursts)
  );

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if ((w_r_hs && (!w_rid_ok || rresp != 2'b00)) || (|w_unf)) r_err <= 1'b1;
  end
  assign err_sticky = r_err;
endmodule

// File: tb/tb_md5_read_scheduler.sv
// Directed bench for md5_read_scheduler (4 lanes, MAX_OUTSTANDING=2): R routing table plus AR/error sequences.
module tb_md5_read_scheduler;
  localparam int NL = 4;

  logic            clk = 1'b0, rst = 1'b1;
  logic [NL-1:0]   lane_req_valid = '0, lane_req_ready, lane_resp_valid, lane_resp_ready = '0;
  logic [NL*64-1:0] lane_req_addr = '0;
  logic [NL*8-1:0] lane_req_len = '0;
  logic [511:0]    lane_resp_data, rdata = '0;
  logic            lane_resp_last, arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready, err_sticky;
  logic [15:0]     arid, rid = '0;
  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      rresp = '0;
  logic [NL*32-1:0] stat_bursts;

  int checks = 0, errors = 0;

  md5_read_scheduler #(.NUM_LANES(NL), .MAX_OUTSTANDING(2), .ID_W(16)) dut (
    .clk(clk), .rst(rst), .lane_req_valid(lane_req_valid), .lane_req_addr(lane_req_addr),
    .lane_req_len(lane_req_len), .lane_req_ready(lane_req_ready), .lane_resp_valid(lane_resp_valid),
    .lane_resp_data(lane_resp_data), .lane_resp_last(lane_resp_last), .lane_resp_ready(lane_resp_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_sticky(err_sticky), .stat_bursts(stat_bursts));

  always #5 clk = ~clk;

  typedef struct {
    logic          rvalid;
    logic [15:0]   rid;
    logic [NL-1:0] rdy;
    logic [511:0]  data;
    logic [NL-1:0] exp_v;
    logic          exp_rready;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; lane_req_valid = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_ar(input int lane);
    int n;
    n = 0;
    lane_req_valid = '0;
    lane_req_valid[lane] = 1'b1;
    #1;
    while (!lane_req_ready[lane] && n < 20) begin tick(); n++; end
    chk("ar_grant_timeout", 64'(n < 20), 64'd1);
    tick();
    lane_req_valid = '0; arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic r_beat(input int id, input logic last, input logic [1:0] resp);
    rvalid = 1'b1; rid = 16'(id); rlast = last; rresp = resp; lane_resp_ready = '1;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = '0;
  endtask

  initial begin
    vec_t tbl[5];
    logic [63:0] exp_s0, exp_s3;
    tbl[0] = '{1'b0, 16'd0, 4'b1111, 512'h0,          4'b0000, 1'b1};
    tbl[1] = '{1'b1, 16'd2, 4'b0100, 512'hDEAD_BEEF,  4'b0100, 1'b1};
    tbl[2] = '{1'b1, 16'd1, 4'b1101, {16{32'hA5A5_0001}}, 4'b0010, 1'b0};
    tbl[3] = '{1'b1, 16'd3, 4'b1000, 512'h1234,       4'b1000, 1'b1};
    tbl[4] = '{1'b1, 16'd0, 4'b0000, ~512'h0,         4'b0001, 1'b0};

    // reset state
    tick(); tick();
    chk("rst_arvalid", 64'(arvalid), 0);
    chk("rst_arid", 64'(arid), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", 64'(arlen), 0);
    chk("rst_arsize", 64'(arsize), 6);
    chk("rst_err", 64'(err_sticky), 0);
    chk("rst_stat", stat_bursts[63:0], 0);
    chk("rst_req_ready", 64'(lane_req_ready), 0);
    rst = 1'b0;

    // R routing table (no rlast, no rresp error)
    for (int i = 0; i < 5; i++) begin
      rvalid = tbl[i].rvalid; rid = tbl[i].rid; lane_resp_ready = tbl[i].rdy; rdata = tbl[i].data;
      #1;
      chk($sformatf("tbl%0d_valid", i), 64'(lane_resp_valid), 64'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_rready", i), 64'(rready), 64'(tbl[i].exp_rready));
      checks++;
      if (lane_resp_data !== tbl[i].data) begin
        errors++;
        $display("FAIL tbl%0d_data: got %0h expected %0h", i, lane_resp_data[63:0], tbl[i].data[63:0]);
      end
      tick();
    end
    rvalid = 1'b0;
    chk("tbl_err", 64'(err_sticky), 0);

    // single lane 2 burst
    do_reset();
    lane_req_valid = 4'b0100; lane_req_addr[2*64 +: 64] = 64'h1000; lane_req_len[2*8 +: 8] = 8'd3;
    #1;
    chk("l2_req_ready", 64'(lane_req_ready), 4'b0100);
    tick();
    lane_req_valid = '0;
    chk("l2_arvalid", 64'(arvalid), 1);
    chk("l2_arid", 64'(arid), 2);
    chk("l2_araddr", araddr, 64'h1000);
    chk("l2_arlen", 64'(arlen), 3);
    chk("l2_arsize", 64'(arsize), 6);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("l2_arvalid_drop", 64'(arvalid), 0);
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rid = 16'd2; rlast = (b == 3); lane_resp_ready = 4'b0100;
      #1;
      chk($sformatf("l2_beat%0d_valid", b), 64'(lane_resp_valid), 4'b0100);
      chk($sformatf("l2_beat%0d_last", b), 64'(lane_resp_last), 64'(b == 3));
      chk($sformatf("l2_beat%0d_rready", b), 64'(rready), 1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    chk("l2_err_after_burst", 64'(err_sticky), 0);
    r_beat(2, 1'b1, 2'b00);
    chk("l2_extra_last_err", 64'(err_sticky), 1);

    // round robin, all lanes, arready=1
    do_reset();
    lane_req_valid = 4'b1111; arready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk($sformatf("rr%0d_grant", g), 64'(lane_req_ready), 64'(1) << (g % 4));
      tick();
      chk($sformatf("rr%0d_arvalid", g), 64'(arvalid), 1);
      chk($sformatf("rr%0d_arid", g), 64'(arid), 64'(g % 4));
      chk($sformatf("rr%0d_issue_ready", g), 64'(lane_req_ready), 0);
      tick();
    end

    // arready stall holds fields
    do_reset();
    lane_req_valid = 4'b0010; lane_req_addr[1*64 +: 64] = 64'h2040; lane_req_len[1*8 +: 8] = 8'd7;
    tick();
    lane_req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_arvalid", c), 64'(arvalid), 1);
      chk($sformatf("stall%0d_araddr", c), araddr, 64'h2040);
      chk($sformatf("stall%0d_arid", c), 64'(arid), 1);
      chk($sformatf("stall%0d_ready", c), 64'(lane_req_ready), 0);
      tick();
    end

    // outstanding limit on lane 1
    do_reset();
    do_ar(1);
    do_ar(1);
    lane_req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lim%0d_ready", c), 64'(lane_req_ready), 0);
      chk($sformatf("lim%0d_arvalid", c), 64'(arvalid), 0);
      tick();
    end
    lane_req_valid = 4'b0011;
    #1;
    chk("lim_other_lane", 64'(lane_req_ready), 4'b0001);
    lane_req_valid = 4'b0010;
    rvalid = 1'b1; rid = 16'd1; rlast = 1'b1; lane_resp_ready = 4'b0010;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    chk("lim_release_ready", 64'(lane_req_ready), 4'b0010);
    tick();
    lane_req_valid = '0;
    chk("lim_third_ar", 64'(arvalid), 1);
    chk("lim_third_arid", 64'(arid), 1);
    chk("lim_err", 64'(err_sticky), 0);

    // error cases
    do_reset();
    rvalid = 1'b1; rid = 16'd7; lane_resp_ready = '0;
    #1;
    chk("bad_rid_rready", 64'(rready), 1);
    chk("bad_rid_valid", 64'(lane_resp_valid), 0);
    tick();
    rvalid = 1'b0;
    chk("bad_rid_err", 64'(err_sticky), 1);
    do_reset();
    chk("err_cleared", 64'(err_sticky), 0);
    rvalid = 1'b1; rid = 16'd2; rresp = 2'd2; lane_resp_ready = 4'b0100;
    #1;
    chk("rresp_valid", 64'(lane_resp_valid), 4'b0100);
    tick();
    rvalid = 1'b0; rresp = '0;
    chk("rresp_err", 64'(err_sticky), 1);

    // burst statistics and reset mid-ISSUE
    do_reset();
    for (int n = 0; n < 3; n++) begin do_ar(0); r_beat(0, 1'b1, 2'b00); end
    do_ar(3); r_beat(3, 1'b1, 2'b00);
`ifdef MD5_SCHED_STATS_EN
    exp_s0 = 64'd3; exp_s3 = 64'd1;
`else
    exp_s0 = 64'd0; exp_s3 = 64'd0;
`endif
    chk("stat_lane0", 64'(stat_bursts[0*32 +: 32]), exp_s0);
    chk("stat_lane3", 64'(stat_bursts[3*32 +: 32]), exp_s3);
    chk("stat_err", 64'(err_sticky), 0);
    lane_req_valid = 4'b0100;
    tick();
    lane_req_valid = '0;
    chk("mid_issue_arvalid", 64'(arvalid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_arvalid", 64'(arvalid), 0);
    chk("post_rst_stat0", 64'(stat_bursts[0*32 +: 32]), 0);
    chk("post_rst_stat3", 64'(stat_bursts[3*32 +: 32]), 0);
    rvalid = 1'b1; rid = 16'd2; rlast = 1'b1; lane_resp_ready = 4'b0100;
    #1;
    chk("late_beat_valid", 64'(lane_resp_valid), 4'b0100);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    chk("late_beat_err", 64'(err_sticky), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md5_read_scheduler.md
Name: md5_read_scheduler

Overview:
- Shares one AXI4 read master (AR/R channels of the app's virtual-memory port) between NUM_LANES MD5 hashing lanes.
- Each lane issues burst read requests; the block round-robin arbitrates them onto AR, tags arid with the lane index, and routes R beats back by rid.
- Enforces a per-lane outstanding-burst limit and records protocol errors.

Parameters:
- NUM_LANES, 4, number of MD5 requesters (1..16).
- MAX_OUTSTANDING, 8, max in-flight bursts per lane (1..255).
- ID_W, 16, AXI ID width.

Ports:
- clk  in  1  user clock.
- rst  in  1  synchronous, active-high reset.
- lane_req_valid  in  NUM_LANES  per-lane burst request valid.
- lane_req_addr  in  NUM_LANES*64  per-lane byte address, 64B-aligned.
- lane_req_len  in  NUM_LANES*8  per-lane AXI len (beats-1).
- lane_req_ready  out  NUM_LANES  request accepted.
- lane_resp_valid  out  NUM_LANES  beat valid for lane.
- lane_resp_data  out  512  shared beat data (rdata).
- lane_resp_last  out  1  shared beat last (rlast).
- lane_resp_ready  in  NUM_LANES  lane can take beat.
- arid, araddr, arlen, arsize  out  ID_W/64/8/3  AXI AR fields.
- arvalid  out  1;  arready  in  1.
- rid  in  ID_W;  rdata  in  512;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1.
- err_sticky  out  1  protocol error seen since reset.
- stat_bursts  out  NUM_LANES*32  per-lane completed-burst count (see optional feature).

Behaviour:
- FSM IDLE/ISSUE.
- IDLE:
  - Eligible lanes: lane_req_valid[i] && outstanding[i] < MAX_OUTSTANDING.
  - Winner: the first eligible lane at or after rr_ptr, searching with wrap.
  - lane_req_ready[winner]=1 combinationally in that cycle only.
  - Register araddr/arlen, arid={zeros,winner}, arsize=3'b110; go to ISSUE.
  - With no eligible lane, stay in IDLE with all lane_req_ready=0.
- ISSUE:
  - arvalid=1, fields held stable.
  - On arready: outstanding[winner]++, rr_ptr=winner+1 mod NUM_LANES, go to IDLE.
  - Minimum 2 cycles per AR; arvalid first asserted the cycle after acceptance.
- R routing (combinational, zero latency):
  - lane_resp_valid[i] = rvalid && rid==i.
  - rready = lane_resp_ready[rid].
  - lane_resp_data=rdata and lane_resp_last=rlast for all lanes.
- Burst completion: R handshake with rlast decrements outstanding[rid]. If the same cycle also has an AR handshake on the same lane, the count is unchanged.
- Error cases:
  - rid >= NUM_LANES: rready=1, beat dropped, err_sticky set.
  - rresp != 0 on any handshaken beat: beat delivered, err_sticky set.
  - R completion on a lane with outstanding==0: no underflow (count stays 0), err_sticky set.
- outstanding counters saturate and never wrap; a lane at MAX_OUTSTANDING is skipped but does not stall other lanes.
- Reset values:
  - state=IDLE, arvalid=0, arid/araddr/arlen=0, arsize=3'b110.
  - rr_ptr=0, all outstanding=0, err_sticky=0, stat_bursts=0, lane_req_ready=0.
- Reset mid-burst drops the pending AR and clears all counters. Beats for pre-reset bursts arriving later are routed by rid normally; their rlast causes an outstanding==0 error.

Optional Feature:
- Macro MD5_SCHED_STATS_EN.
- Defined: stat_bursts[i] increments (wrapping at 2^32) on every R handshake with rlast and rid==i; cleared by rst.
- Undefined: no counters are built; stat_bursts is tied to 0.

Test Plan:
- Single lane 2, addr 0x1000, len 3 -> arid=2, araddr=0x1000, arlen=3, arsize=6; 4 R beats rid=2 delivered only to lane 2; last on beat 4; outstanding[2] returns to 0.
- All 4 lanes valid continuously, arready=1 -> grant order 0,1,2,3,0 with one AR every 2 cycles.
- MAX_OUTSTANDING=2, lane 1 alone, no R returned -> 2 ARs issued then lane_req_ready[1] stays 0; one rlast rid=1 -> third AR issued.
- arready held 0 for 5 cycles in ISSUE -> arvalid and fields stable; lane_req_ready all 0.
- rid=7 with NUM_LANES=4 -> rready=1, no lane_resp_valid, err_sticky=1; also rresp=2 on a valid lane -> beat delivered, err_sticky=1.
- Macro defined: 3 bursts to lane 0, 1 to lane 3 -> stat_bursts lane0=3, lane3=1; rst mid-ISSUE -> arvalid=0 next cycle, counters 0.
